// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and lane slicing helper for the fetch stage
`ifndef FETCH_PKG_SV
`define FETCH_PKG_SV

// Part-select of lane `lane` in a flat bus whose lanes are `width` bits wide.
`define FETCH_LANE(lane, width) ((lane)*(width)) +: (width)

package fetch_pkg;
    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    typedef enum logic {
        FS_BOOT = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_t;
endpackage

`endif

// File: rtl/fetch_stage_mw_pc_gen.sv
// rtl/fetch_stage_mw_pc_gen.sv - fetch PC generator: PC/pending-redirect registers, BOOT/RUN FSM, fetch_pc mux
// Ports:
//   CLK, RST_N     clock, asynchronous active-low reset
//   ex_setPC/ex_PC redirect request and target from EX
//   out_ready      decode accepts the current bundle
//   out_valid      bundle valid (RUN state)
//   fetch_pc       byte address of lane 0 of the current bundle
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int          ISSUE_W  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ex_setPC,
    input  logic [31:0] ex_PC,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] fetch_pc
);
    localparam logic [31:0] BUNDLE_BYTES = 32'(PC_STEP * ISSUE_W);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_redir_pend;
    logic         w_redir_pend_nxt;
    logic [31:0]  r_redir_pc;
    logic [31:0]  w_redir_pc_nxt;
    logic [31:0]  w_ex_target;

    assign w_ex_target = {ex_PC[31:2], 2'b00};

    // A live redirect beats a latched one, which beats the sequential PC.
    assign fetch_pc  = ex_setPC ? w_ex_target : (r_redir_pend ? r_redir_pc : r_pc);
    assign out_valid = (r_state == FS_RUN);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= FS_BOOT;
            r_pc         <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_redir_pend <= w_redir_pend_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_redir_pend_nxt = r_redir_pend;
        w_redir_pc_nxt   = r_redir_pc;
        case (r_state)
            FS_BOOT: begin
                w_state_nxt = FS_RUN;
                if (ex_setPC) begin
                    w_redir_pend_nxt = 1'b1;
                    w_redir_pc_nxt   = w_ex_target;
                end
            end
            FS_RUN: begin
                if (out_ready) begin
                    w_pc_nxt         = fetch_pc + BUNDLE_BYTES;
                    w_redir_pend_nxt = 1'b0;
                end else if (ex_setPC) begin
                    // Held so the stalled bundle keeps showing the newest target.
                    w_redir_pend_nxt = 1'b1;
                    w_redir_pc_nxt   = w_ex_target;
                end
            end
            default: w_state_nxt = FS_BOOT;
        endcase
    end
endmodule

// File: rtl/fetch_stage_mw.sv
// rtl/fetch_stage_mw.sv - multi-issue instruction fetch with decode backpressure and perf counters
// Ports:
//   CLK, RST_N     clock, asynchronous active-low reset
//   ROM_A          lane i IMem word index at [i*ROM_AW +: ROM_AW]
//   ROM_RD         lane i IMem read data at [i*32 +: 32]
//   ex_setPC/ex_PC redirect request and target
//   out_ready      decode accepts bundle
//   out_valid      bundle valid
//   out_PC         lane i: address following lane i
//   out_inst       lane i instruction
//   perf_fetch     bundles accepted
//   perf_stall     cycles stalled by decode
//   perf_redir     redirects seen
module fetch_stage_mw
    import fetch_pkg::*;
#(
    parameter int          ISSUE_W  = 2,
    parameter int          ROM_AW   = 6,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          CNT_W    = 32
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    output logic [ISSUE_W*ROM_AW-1:0] ROM_A,
    input  logic [ISSUE_W*INST_W-1:0] ROM_RD,
    input  logic                      ex_setPC,
    input  logic [31:0]               ex_PC,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [ISSUE_W*32-1:0]     out_PC,
    output logic [ISSUE_W*INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]          perf_fetch,
    output logic [CNT_W-1:0]          perf_stall,
    output logic [CNT_W-1:0]          perf_redir
);
    logic [31:0]      w_fetch_pc;
    logic [ROM_AW-1:0] w_base_idx;
    logic [CNT_W-1:0] r_perf_fetch;
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_redir;

    fetch_pc_gen #(
        .ISSUE_W  (ISSUE_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ex_setPC  (ex_setPC),
        .ex_PC     (ex_PC),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .fetch_pc  (w_fetch_pc)
    );

    assign w_base_idx = w_fetch_pc[ROM_AW+1:2];

    for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
        // Index arithmetic is ROM_AW bits wide so each lane wraps on its own.
        assign ROM_A[`FETCH_LANE(i, ROM_AW)]  = w_base_idx + ROM_AW'(i);
        assign out_PC[`FETCH_LANE(i, 32)]     = w_fetch_pc + 32'(PC_STEP * (i + 1));
        assign out_inst[`FETCH_LANE(i, INST_W)] = ROM_RD[`FETCH_LANE(i, INST_W)];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
            r_perf_redir <= '0;
        end else begin
            if (out_valid && out_ready) begin
                r_perf_fetch <= r_perf_fetch + 1'b1;
            end
            if (out_valid && !out_ready) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
            if (ex_setPC) begin
                r_perf_redir <= r_perf_redir + 1'b1;
            end
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_stall = r_perf_stall;
    assign perf_redir = r_perf_redir;
endmodule

// File: tb/tb_fetch_stage_mw.sv
// tb/tb_fetch_stage_mw.sv - self-checking bench for fetch_stage_mw against a behavioural model
module tb_fetch_stage_mw;
    logic        CLK;
    logic        RST_N;
    logic        ex_setPC;
    logic [31:0] ex_PC;
    logic        out_ready;

    logic [11:0]  rom_a2;
    logic [63:0]  rom_rd2;
    logic         out_valid2;
    logic [63:0]  out_pc2;
    logic [63:0]  out_inst2;
    logic [31:0]  perf_fetch2, perf_stall2, perf_redir2;

    logic [23:0]  rom_a4;
    logic [127:0] rom_rd4;
    logic         out_valid4;
    logic [127:0] out_pc4;
    logic [127:0] out_inst4;
    logic [3:0]   perf_fetch4, perf_stall4, perf_redir4;

    logic [31:0] rom [64];

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage_mw #(.ISSUE_W(2), .ROM_AW(6), .RESET_PC(32'h0), .CNT_W(32)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .ROM_A(rom_a2), .ROM_RD(rom_rd2),
        .ex_setPC(ex_setPC), .ex_PC(ex_PC), .out_ready(out_ready),
        .out_valid(out_valid2), .out_PC(out_pc2), .out_inst(out_inst2),
        .perf_fetch(perf_fetch2), .perf_stall(perf_stall2), .perf_redir(perf_redir2)
    );

    fetch_stage_mw #(.ISSUE_W(4), .ROM_AW(6), .RESET_PC(32'h0), .CNT_W(4)) u_dut4 (
        .CLK(CLK), .RST_N(RST_N), .ROM_A(rom_a4), .ROM_RD(rom_rd4),
        .ex_setPC(ex_setPC), .ex_PC(ex_PC), .out_ready(out_ready),
        .out_valid(out_valid4), .out_PC(out_pc4), .out_inst(out_inst4),
        .perf_fetch(perf_fetch4), .perf_stall(perf_stall4), .perf_redir(perf_redir4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        rom_rd2 = '0;
        rom_rd4 = '0;
        for (int i = 0; i < 2; i++) rom_rd2[i*32 +: 32] = rom[rom_a2[i*6 +: 6]];
        for (int i = 0; i < 4; i++) rom_rd4[i*32 +: 32] = rom[rom_a4[i*6 +: 6]];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_lanes(input string tag, input int n, input logic [31:0] fpc,
                             input logic [23:0] a, input logic [127:0] pcv, input logic [127:0] inst);
        logic [5:0] idx;
        for (int i = 0; i < n; i++) begin
            idx = fpc[7:2] + 6'(i);
            chk($sformatf("%s_rom_a%0d", tag, i), 32'(a[i*6 +: 6]), 32'(idx));
            chk($sformatf("%s_out_pc%0d", tag, i), pcv[i*32 +: 32], fpc + 32'(4 * (i + 1)));
            chk($sformatf("%s_inst%0d", tag, i), inst[i*32 +: 32], rom[idx]);
        end
    endtask

    // Behavioural model: "next bundle address" per instance, one pending redirect target.
    logic [31:0] m_pc [2];
    logic        m_pend;
    logic [31:0] m_ppc;
    logic        m_run;
    int unsigned m_fetch, m_stall, m_redir;
    logic [31:0] f0, f1, tgt;

    always @(negedge CLK) begin
        if (!RST_N) begin
            m_pc[0] = 32'h0;
            m_pc[1] = 32'h0;
            m_pend  = 1'b0;
            m_ppc   = 32'h0;
            m_run   = 1'b0;
            m_fetch = 0;
            m_stall = 0;
            m_redir = 0;
            chk("rst_valid2", 32'(out_valid2), 32'h0);
            chk("rst_valid4", 32'(out_valid4), 32'h0);
            chk("rst_fetch2", perf_fetch2, 32'h0);
            chk("rst_stall2", perf_stall2, 32'h0);
            chk("rst_redir2", perf_redir2, 32'h0);
        end else begin
            tgt = {ex_PC[31:2], 2'b00};
            f0  = ex_setPC ? tgt : (m_pend ? m_ppc : m_pc[0]);
            f1  = ex_setPC ? tgt : (m_pend ? m_ppc : m_pc[1]);
            chk("valid2", 32'(out_valid2), 32'(m_run));
            chk("valid4", 32'(out_valid4), 32'(m_run));
            if (m_run) begin
                chk_lanes("w2", 2, f0, 24'(rom_a2), 128'(out_pc2), 128'(out_inst2));
                chk_lanes("w4", 4, f1, rom_a4, out_pc4, out_inst4);
            end
            chk("perf_fetch2", perf_fetch2, m_fetch);
            chk("perf_stall2", perf_stall2, m_stall);
            chk("perf_redir2", perf_redir2, m_redir);
            chk("perf_fetch4", 32'(perf_fetch4), m_fetch % 16);
            chk("perf_stall4", 32'(perf_stall4), m_stall % 16);
            chk("perf_redir4", 32'(perf_redir4), m_redir % 16);
            if (ex_setPC) m_redir++;
            if (!m_run) begin
                if (ex_setPC) begin
                    m_pend = 1'b1;
                    m_ppc  = tgt;
                end
                m_run = 1'b1;
            end else if (out_ready) begin
                m_pc[0] = f0 + 32'd8;
                m_pc[1] = f1 + 32'd16;
                m_pend  = 1'b0;
                m_fetch++;
            end else begin
                m_stall++;
                if (ex_setPC) begin
                    m_pend = 1'b1;
                    m_ppc  = tgt;
                end
            end
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        RST_N     = 1'b0;
        out_ready = 1'b1;
        ex_setPC  = 1'b0;
        ex_PC     = 32'h0;
        step();
        step();
        RST_N = 1'b1;
        #1 chk("lit_boot_valid", 32'(out_valid2), 32'h0);
        step(); #1 chk("lit_pc0_rom_a", 32'(rom_a2), 32'h040);
        chk("lit_pc0_out_pc", out_pc2[63:32], 32'h8);
        step(); #1 chk("lit_pc8_rom_a", 32'(rom_a2), 32'h0C2);
        step(); out_ready = 1'b0;
        #1 chk("lit_stall1_rom_a", 32'(rom_a2), 32'h144);
        step(); #1 chk("lit_stall2_rom_a", 32'(rom_a2), 32'h144);
        step(); #1 chk("lit_stall3_rom_a", 32'(rom_a2), 32'h144);
        step(); out_ready = 1'b1;
        #1 chk("lit_stall_cnt", perf_stall2, 32'd3);
        chk("lit_fire10_rom_a", 32'(rom_a2), 32'h144);
        step(); ex_setPC = 1'b1; ex_PC = 32'h40;
        #1 chk("lit_redir_rom_a", 32'(rom_a2), 32'h450);
        chk("lit_redir_pc0", out_pc2[31:0], 32'h44);
        chk("lit_redir_pc1", out_pc2[63:32], 32'h48);
        step(); ex_setPC = 1'b0;
        #1 chk("lit_after_redir_rom_a", 32'(rom_a2), 32'h4D2);
        out_ready = 1'b0; ex_setPC = 1'b1; ex_PC = 32'h80;
        step(); ex_PC = 32'h90;
        step(); ex_setPC = 1'b0; out_ready = 1'b1;
        #1 chk("lit_newest_redir_rom_a", 32'(rom_a2), 32'h964);
        step(); #1 chk("lit_after_90_rom_a", 32'(rom_a2), 32'h9E6);
        chk("lit_redir_cnt", perf_redir2, 32'd3);
        chk("lit_fetch_cnt", perf_fetch2, 32'd5);
        chk("lit_stall_cnt2", perf_stall2, 32'd5);
        step(); out_ready = 1'b0; ex_setPC = 1'b1; ex_PC = 32'h20;
        step(); ex_setPC = 1'b0;
        #1 chk("lit_pend_rom_a", 32'(rom_a2), 32'h248);
        step(); RST_N = 1'b0;
        #1 chk("lit_async_valid", 32'(out_valid2), 32'h0);
        chk("lit_async_fetch", perf_fetch2, 32'h0);
        chk("lit_async_redir", perf_redir2, 32'h0);
        step(); RST_N = 1'b1; out_ready = 1'b1;
        step(); #1 chk("lit_resume_rom_a", 32'(rom_a2), 32'h040);
        step(); ex_setPC = 1'b1; ex_PC = 32'hFC;
        #1 chk("lit_wrap4_rom_a", 32'(rom_a4), 32'h08103F);
        chk("lit_wrap4_pc0", out_pc4[31:0], 32'h100);
        chk("lit_wrap4_pc3", out_pc4[127:96], 32'h10C);
        step(); ex_setPC = 1'b0;

        for (int c = 0; c < 800; c++) begin
            step();
            if (!RST_N) RST_N = 1'b1;
            else if ($urandom_range(0, 199) == 0) RST_N = 1'b0;
            out_ready = ($urandom_range(0, 9) < 7);
            ex_setPC  = ($urandom_range(0, 9) == 0);
            ex_PC     = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : 32'($urandom);
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
